// File: rtl/mmul_parallel_dispatcher.sv
// Job dispatcher that feeds queued matrix-multiply jobs to a pool of replicated engines
// and returns a per-core completion event when each job finishes.
module mmul_parallel_dispatcher #(
    parameter int N_ENGINES  = 2,
    parameter int N_CORES    = 2,
    parameter int JOB_DEPTH  = 4,
    parameter int LEN_WIDTH  = 16,
    localparam int CORE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           enable_i,
    input  logic                           job_valid_i,
    output logic                           job_ready_o,
    input  logic [LEN_WIDTH-1:0]           job_len_i,
    input  logic [CORE_W-1:0]              job_core_i,
    output logic [N_ENGINES-1:0]           eng_start_o,
    output logic [N_ENGINES*LEN_WIDTH-1:0] eng_len_o,
    input  logic [N_ENGINES-1:0]           eng_done_i,
    output logic [N_CORES-1:0]             evt_o,
    output logic                           busy_o,
    output logic [31:0]                    jobs_done_o
);

    localparam int ENG_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
    localparam int SEL_W = ENG_W + 1;
    localparam int PTR_W = $clog2(JOB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LEN_WIDTH-1:0] fifo_len_r  [JOB_DEPTH];
    logic [CORE_W-1:0]    fifo_core_r [JOB_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 dispatch_s;
    logic                 zero_pop_s;
    logic [LEN_WIDTH-1:0] head_len_s;
    logic [CORE_W-1:0]    head_core_s;
    logic [CORE_W-1:0]    push_core_s;

    logic [N_ENGINES-1:0] busy_r;
    logic [N_ENGINES-1:0] start_r;
    logic [N_ENGINES-1:0] acc_done_s;
    logic [CORE_W-1:0]    owner_r [N_ENGINES];
    logic [LEN_WIDTH-1:0] len_r   [N_ENGINES];

    logic [ENG_W-1:0]     rr_ptr_r;
    logic [ENG_W-1:0]     rr_next_s;
    logic [ENG_W-1:0]     sel_idx_s;
    logic                 sel_found_s;
    logic [SEL_W-1:0]     cand_s;

    logic [N_CORES-1:0]   evt_r;
    logic [N_CORES-1:0]   evt_next_s;
    logic [31:0]          jobs_done_r;
    logic [31:0]          done_inc_s;

    assign fifo_full_s  = (count_r == CNT_W'(JOB_DEPTH));
    assign fifo_empty_s = (count_r == '0);
    assign job_ready_o  = rst_ni & ~fifo_full_s & ~clear_i;
    assign push_s       = job_valid_i & job_ready_o;
    assign pop_s        = dispatch_s | zero_pop_s;
    assign head_len_s   = fifo_len_r[rd_ptr_r];
    assign head_core_s  = fifo_core_r[rd_ptr_r];
    assign acc_done_s   = eng_done_i & busy_r;

    // Out-of-range core ids are folded onto core 0 so an event always has a target.
    assign push_core_s  = (32'(job_core_i) < 32'(N_CORES)) ? job_core_i : '0;

    // Round-robin search for the first idle engine at or after rr_ptr_r.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < N_ENGINES; k++) begin
            cand_s = {1'b0, rr_ptr_r} + SEL_W'(k);
            if (cand_s >= SEL_W'(N_ENGINES)) begin
                cand_s = cand_s - SEL_W'(N_ENGINES);
            end else begin
                cand_s = cand_s;
            end
            if (!sel_found_s && !busy_r[cand_s[ENG_W-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s[ENG_W-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pointer advance past the engine just chosen.
    always_comb begin
        if (32'(sel_idx_s) == 32'(N_ENGINES - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = sel_idx_s + ENG_W'(1);
        end
    end

    // Head-of-queue decision: zero-length jobs retire without needing an engine.
    always_comb begin
        dispatch_s = 1'b0;
        zero_pop_s = 1'b0;
        if (enable_i && !fifo_empty_s && !clear_i) begin
            if (head_len_s == '0) begin
                zero_pop_s = 1'b1;
            end else if (sel_found_s) begin
                dispatch_s = 1'b1;
            end else begin
                dispatch_s = 1'b0;
            end
        end else begin
            dispatch_s = 1'b0;
        end
    end

    // Completion events merge per core; the counter adds every retirement this cycle.
    always_comb begin
        evt_next_s = '0;
        done_inc_s = 32'd0;
        for (int i = 0; i < N_ENGINES; i++) begin
            evt_next_s[owner_r[i]] = evt_next_s[owner_r[i]] | acc_done_s[i];
            done_inc_s             = done_inc_s + 32'(acc_done_s[i]);
        end
        evt_next_s[head_core_s] = evt_next_s[head_core_s] | zero_pop_s;
        done_inc_s              = done_inc_s + 32'(zero_pop_s);
    end

    // Job FIFO storage and pointers; no fall-through from input to head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < JOB_DEPTH; i++) begin
                fifo_len_r[i]  <= '0;
                fifo_core_r[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_len_r[wr_ptr_r]  <= job_len_i;
                fifo_core_r[wr_ptr_r] <= push_core_s;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Per-engine ownership, start pulse and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r   <= '0;
            start_r  <= '0;
            rr_ptr_r <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                owner_r[i] <= '0;
                len_r[i]   <= '0;
            end
        end else if (clear_i) begin
            busy_r   <= '0;
            start_r  <= '0;
            rr_ptr_r <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                owner_r[i] <= '0;
                len_r[i]   <= '0;
            end
        end else begin
            start_r <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                if (acc_done_s[i]) begin
                    busy_r[i] <= 1'b0;
                    len_r[i]  <= '0;
                end
            end
            // The selected engine is idle, so it cannot collide with a done above.
            if (dispatch_s) begin
                busy_r[sel_idx_s]  <= 1'b1;
                start_r[sel_idx_s] <= 1'b1;
                owner_r[sel_idx_s] <= head_core_s;
                len_r[sel_idx_s]   <= head_len_s;
                rr_ptr_r           <= rr_next_s;
            end
        end
    end

    // Event pulses and the wrapping completed-job counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_r       <= '0;
            jobs_done_r <= 32'd0;
        end else if (clear_i) begin
            evt_r       <= '0;
            jobs_done_r <= 32'd0;
        end else begin
            evt_r       <= evt_next_s;
            jobs_done_r <= jobs_done_r + done_inc_s;
        end
    end

    for (genvar g = 0; g < N_ENGINES; g++) begin : g_len
        assign eng_len_o[g*LEN_WIDTH +: LEN_WIDTH] = len_r[g];
    end

    assign eng_start_o = start_r;
    assign evt_o       = evt_r;
    assign jobs_done_o = jobs_done_r;
    assign busy_o      = ~fifo_empty_s | (|busy_r) | (|start_r);

endmodule

// File: tb/tb_mmul_parallel_dispatcher.sv
// Directed bench for mmul_parallel_dispatcher with the default 2-engine, 2-core, depth-4 setup.
module tb_mmul_parallel_dispatcher;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        enable_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [15:0] job_len_i;
    logic [0:0]  job_core_i;
    logic [1:0]  eng_start_o;
    logic [31:0] eng_len_o;
    logic [1:0]  eng_done_i;
    logic [1:0]  evt_o;
    logic        busy_o;
    logic [31:0] jobs_done_o;

    int n_checks;
    int n_errors;

    mmul_parallel_dispatcher dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .enable_i    (enable_i),
        .job_valid_i (job_valid_i),
        .job_ready_o (job_ready_o),
        .job_len_i   (job_len_i),
        .job_core_i  (job_core_i),
        .eng_start_o (eng_start_o),
        .eng_len_o   (eng_len_o),
        .eng_done_i  (eng_done_i),
        .evt_o       (evt_o),
        .busy_o      (busy_o),
        .jobs_done_o (jobs_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic submit(input logic [15:0] len, input logic [0:0] core);
        job_valid_i = 1'b1;
        job_len_i   = len;
        job_core_i  = core;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        enable_i    = 1'b1;
        job_valid_i = 1'b0;
        job_len_i   = 16'd0;
        job_core_i  = 1'b0;
        eng_done_i  = 2'b00;

        // reset state
        #1;
        check_val("rst_ready", 32'(job_ready_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(job_ready_o), 32'd1);
        check_val("post_rst_start", 32'(eng_start_o), 32'd0);
        check_val("post_rst_evt", 32'(evt_o), 32'd0);
        check_val("post_rst_cnt", jobs_done_o, 32'd0);
        check_val("post_rst_len", eng_len_o, 32'd0);

        // single job, len 5 core 1, submitted in cycle 0
        submit(16'd5, 1'b1);
        tick();                                   // cycle 1
        job_valid_i = 1'b0;
        check_val("t1_c1_start", 32'(eng_start_o), 32'd0);
        check_val("t1_c1_busy", 32'(busy_o), 32'd1);
        tick();                                   // cycle 2
        check_val("t1_start", 32'(eng_start_o), 32'b01);
        check_val("t1_len0", 32'(eng_len_o[15:0]), 32'd5);
        tick();                                   // cycle 3
        check_val("t1_start_gone", 32'(eng_start_o), 32'd0);
        check_val("t1_len_hold", 32'(eng_len_o[15:0]), 32'd5);
        repeat (7) tick();                        // cycle 10
        eng_done_i = 2'b01;
        tick();                                   // cycle 11
        eng_done_i = 2'b00;
        check_val("t1_evt", 32'(evt_o), 32'b10);
        check_val("t1_cnt", jobs_done_o, 32'd1);
        check_val("t1_idle", 32'(busy_o), 32'd0);
        tick();
        check_val("t1_evt_gone", 32'(evt_o), 32'd0);

        // soft clear returns rr pointer and counter to zero
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_val("clr1_cnt", jobs_done_o, 32'd0);

        // three back-to-back jobs, two engines
        submit(16'd7, 1'b0);
        tick();
        submit(16'd8, 1'b1);
        tick();
        check_val("t2_start_e0", 32'(eng_start_o), 32'b01);
        check_val("t2_len0", 32'(eng_len_o[15:0]), 32'd7);
        submit(16'd9, 1'b0);
        tick();
        job_valid_i = 1'b0;
        check_val("t2_start_e1", 32'(eng_start_o), 32'b10);
        check_val("t2_len1", 32'(eng_len_o[31:16]), 32'd8);
        tick();
        check_val("t2_wait", 32'(eng_start_o), 32'd0);
        check_val("t2_busy", 32'(busy_o), 32'd1);
        eng_done_i = 2'b01;
        tick();
        eng_done_i = 2'b00;
        check_val("t2_evt", 32'(evt_o), 32'b01);
        check_val("t2_no_start_yet", 32'(eng_start_o), 32'd0);
        tick();
        check_val("t2_start_third", 32'(eng_start_o), 32'b01);
        check_val("t2_len0_third", 32'(eng_len_o[15:0]), 32'd9);
        check_val("t2_cnt", jobs_done_o, 32'd1);

        // zero-length job with both engines busy
        submit(16'd0, 1'b0);
        tick();
        job_valid_i = 1'b0;
        check_val("t4_no_start_a", 32'(eng_start_o), 32'd0);
        tick();
        check_val("t4_evt", 32'(evt_o), 32'b01);
        check_val("t4_cnt", jobs_done_o, 32'd2);
        check_val("t4_no_start_b", 32'(eng_start_o), 32'd0);

        // clear with two busy engines and two queued jobs
        submit(16'd3, 1'b1);
        tick();
        submit(16'd4, 1'b0);
        tick();
        job_valid_i = 1'b0;
        check_val("t6_busy_before", 32'(busy_o), 32'd1);
        clear_i    = 1'b1;
        eng_done_i = 2'b11;
        #1;
        check_val("t6_ready_in_clear", 32'(job_ready_o), 32'd0);
        tick();
        clear_i    = 1'b0;
        check_val("t6_busy", 32'(busy_o), 32'd0);
        check_val("t6_cnt", jobs_done_o, 32'd0);
        check_val("t6_evt", 32'(evt_o), 32'd0);
        check_val("t6_start", 32'(eng_start_o), 32'd0);
        check_val("t6_len", eng_len_o, 32'd0);
        tick();
        eng_done_i = 2'b00;
        check_val("t6_late_evt", 32'(evt_o), 32'd0);
        check_val("t6_late_cnt", jobs_done_o, 32'd0);

        // both engines finish together, both owned by core 1
        submit(16'd2, 1'b1);
        tick();
        submit(16'd3, 1'b1);
        tick();
        job_valid_i = 1'b0;
        check_val("t5_start_e0", 32'(eng_start_o), 32'b01);
        tick();
        check_val("t5_start_e1", 32'(eng_start_o), 32'b10);
        eng_done_i = 2'b11;
        tick();
        eng_done_i = 2'b00;
        check_val("t5_evt", 32'(evt_o), 32'b10);
        check_val("t5_cnt", jobs_done_o, 32'd2);
        check_val("t5_idle", 32'(busy_o), 32'd0);
        tick();
        check_val("t5_evt_gone", 32'(evt_o), 32'd0);

        // fill the FIFO with dispatch disabled
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            submit(16'(i + 1), 1'b0);
            check_val("t3_ready_fill", 32'(job_ready_o), 32'd1);
            tick();
        end
        submit(16'd5, 1'b0);
        check_val("t3_full", 32'(job_ready_o), 32'd0);
        check_val("t3_busy", 32'(busy_o), 32'd1);
        repeat (2) begin
            tick();
            check_val("t3_still_full", 32'(job_ready_o), 32'd0);
            check_val("t3_no_start", 32'(eng_start_o), 32'd0);
        end
        enable_i = 1'b1;
        #1;
        check_val("t3_full_on_pop", 32'(job_ready_o), 32'd0);
        tick();
        check_val("t3_ready_back", 32'(job_ready_o), 32'd1);
        check_val("t3_start_e0", 32'(eng_start_o), 32'b01);
        check_val("t3_len0", 32'(eng_len_o[15:0]), 32'd1);
        tick();
        job_valid_i = 1'b0;
        check_val("t3_start_e1", 32'(eng_start_o), 32'b10);
        check_val("t3_len1", 32'(eng_len_o[31:16]), 32'd2);

        // disabling dispatch does not stop done handling
        enable_i   = 1'b0;
        eng_done_i = 2'b01;
        tick();
        eng_done_i = 2'b00;
        check_val("t7_evt", 32'(evt_o), 32'b01);
        check_val("t7_cnt", jobs_done_o, 32'd3);
        check_val("t7_no_start", 32'(eng_start_o), 32'd0);
        tick();
        check_val("t7_held", 32'(eng_start_o), 32'd0);
        check_val("t7_busy", 32'(busy_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
